// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 64-bit LEGv8 core.
// Optional build macro IF_ID_PERF_COUNTERS_EN adds the fetched-instruction and stall-cycle counters.
module if_id_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_en,
  input  logic [63:0] i_redirect_pc,
  output logic [63:0] o_pc,
  output logic [31:0] o_if_id_instr,
  output logic [63:0] o_if_id_pc,
  output logic        o_if_id_valid
`ifdef IF_ID_PERF_COUNTERS_EN
  ,
  output logic [63:0] o_perf_fetched,
  output logic [63:0] o_perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    ACT_LOAD,
    ACT_WAIT,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_REDIRECT
  } action_t;

  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

  logic [63:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [63:0] r_if_id_pc;
  logic        r_if_id_valid;

  action_t     w_action;
  logic [63:0] w_pc_plus4;
  logic [63:0] w_redirect_aligned;
  logic [63:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [63:0] w_ipc_next;
  logic        w_valid_next;

  assign w_pc_plus4         = r_pc + 64'd4;
  assign w_redirect_aligned = i_redirect_pc & PC_ALIGN_MASK;

  // Priority below reset: redirect > stall > flush > imem wait > normal fetch.
  always_comb begin
    w_action = ACT_LOAD;
    if (i_redirect_en) begin
      w_action = ACT_REDIRECT;
    end else if (i_stall) begin
      w_action = ACT_HOLD;
    end else if (i_flush) begin
      w_action = ACT_FLUSH;
    end else if (!i_imem_valid) begin
      w_action = ACT_WAIT;
    end
  end

  always_comb begin
    w_pc_next    = r_pc;
    w_instr_next = r_if_id_instr;
    w_ipc_next   = r_if_id_pc;
    w_valid_next = r_if_id_valid;
    unique case (w_action)
      ACT_LOAD: begin
        w_pc_next    = w_pc_plus4;
        w_instr_next = i_imem_rdata;
        w_ipc_next   = r_pc;
        w_valid_next = 1'b1;
      end
      ACT_WAIT: begin
        w_instr_next = NOP_INSTR;
        w_ipc_next   = r_pc;
        w_valid_next = 1'b0;
      end
      ACT_FLUSH: begin
        // A flushed word was still fetched, so the PC moves on if it arrived.
        w_pc_next    = i_imem_valid ? w_pc_plus4 : r_pc;
        w_instr_next = NOP_INSTR;
        w_ipc_next   = r_pc;
        w_valid_next = 1'b0;
      end
      ACT_REDIRECT: begin
        w_pc_next    = w_redirect_aligned;
        w_instr_next = NOP_INSTR;
        w_ipc_next   = r_pc;
        w_valid_next = 1'b0;
      end
      ACT_HOLD: begin
        w_pc_next    = r_pc;
      end
      default: begin
        w_pc_next    = r_pc;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc          <= RESET_PC & PC_ALIGN_MASK;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= 64'h0;
      r_if_id_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_if_id_instr <= w_instr_next;
      r_if_id_pc    <= w_ipc_next;
      r_if_id_valid <= w_valid_next;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_valid = r_if_id_valid;

`ifdef IF_ID_PERF_COUNTERS_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_stall_cycles;

  // Stall cycles count even when a redirect overrides the stall.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_perf_fetched      <= 64'h0;
      r_perf_stall_cycles <= 64'h0;
    end else begin
      if (w_action == ACT_LOAD) begin
        r_perf_fetched <= r_perf_fetched + 64'd1;
      end
      if (i_stall) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 64'd1;
      end
    end
  end

  assign o_perf_fetched      = r_perf_fetched;
  assign o_perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_if_id_fetch_stage;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
`ifdef IF_ID_PERF_COUNTERS_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic        m_valid;
  logic [63:0] m_fetched;
  logic [63:0] m_stalls;

  always #5 clk = ~clk;

  if_id_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .i_imem_valid  (imem_valid),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_redirect_en (redirect_en),
    .i_redirect_pc (redirect_pc),
    .o_pc          (pc),
    .o_if_id_instr (if_id_instr),
    .o_if_id_pc    (if_id_pc),
    .o_if_id_valid (if_id_valid)
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    .o_perf_fetched      (perf_fetched),
    .o_perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Applies the fetch-stage rules to the model for one rising edge.
  task automatic model_step();
    if (!reset) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 64'h0; m_valid = 1'b0;
      m_fetched = 64'h0; m_stalls = 64'h0;
    end else begin
      if (stall) m_stalls = m_stalls + 1;
      if (redirect_en) begin
        m_ipc = m_pc; m_instr = NOP_INSTR; m_valid = 1'b0;
        m_pc = (redirect_pc / 4) * 4;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (flush || !imem_valid) begin
        m_ipc = m_pc; m_instr = NOP_INSTR; m_valid = 1'b0;
        if (flush && imem_valid) m_pc = m_pc + 4;
      end else begin
        m_ipc = m_pc; m_instr = imem_rdata; m_valid = 1'b1;
        m_pc = m_pc + 4;
        m_fetched = m_fetched + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; imem_valid = 1'b1; imem_rdata = $urandom();
    stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = 64'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    redirect_en = 1'b1; redirect_pc = 64'h1234;
    cyc(); cyc();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); end
    checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr got %h exp %h", if_id_instr, NOP_INSTR); end
    checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 0", if_id_pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
  endtask

  task automatic test_stream();
    idle_inputs();
    imem_rdata = 32'h8B020020;
    cyc();
    checks++; if (pc !== 64'h4) begin errors++; $display("FAIL stream_pc1 got %h exp 4", pc); end
    checks++; if (if_id_instr !== 32'h8B020020) begin errors++; $display("FAIL stream_instr1 got %h exp 8B020020", if_id_instr); end
    checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL stream_ifid_pc1 got %h exp 0", if_id_pc); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid1 got %b exp 1", if_id_valid); end
    imem_rdata = 32'h91000421;
    cyc();
    checks++; if (pc !== 64'h8) begin errors++; $display("FAIL stream_pc2 got %h exp 8", pc); end
    checks++; if (if_id_instr !== 32'h91000421) begin errors++; $display("FAIL stream_instr2 got %h exp 91000421", if_id_instr); end
    checks++; if (if_id_pc !== 64'h4) begin errors++; $display("FAIL stream_ifid_pc2 got %h exp 4", if_id_pc); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid2 got %b exp 1", if_id_valid); end
  endtask

  task automatic test_stall();
    idle_inputs();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = $urandom();
      imem_valid = i[0];
      flush = (i == 1);
      cyc();
      checks++; if (pc !== 64'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 8", i, pc); end
      checks++; if (if_id_instr !== 32'h91000421) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 91000421", i, if_id_instr); end
      checks++; if (if_id_pc !== 64'h4) begin errors++; $display("FAIL stall_ifid_pc[%0d] got %h exp 4", i, if_id_pc); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, if_id_valid); end
    end
    idle_inputs();
    imem_rdata = 32'hD2800001;
    cyc();
    checks++; if (pc !== 64'hC) begin errors++; $display("FAIL unstall_pc got %h exp c", pc); end
    checks++; if (if_id_instr !== 32'hD2800001) begin errors++; $display("FAIL unstall_instr got %h exp D2800001", if_id_instr); end
    checks++; if (if_id_pc !== 64'h8) begin errors++; $display("FAIL unstall_ifid_pc got %h exp 8", if_id_pc); end
  endtask

  task automatic test_redirect_stall();
    idle_inputs();
    redirect_en = 1'b1; redirect_pc = 64'h0000_0000_0000_0103; stall = 1'b1; flush = 1'b1;
    cyc();
    checks++; if (pc !== 64'h100) begin errors++; $display("FAIL redir_pc got %h exp 100", pc); end
    checks++; if (imem_addr !== 64'h100) begin errors++; $display("FAIL redir_addr got %h exp 100", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL redir_instr got %h exp %h", if_id_instr, NOP_INSTR); end
  endtask

  task automatic test_flush_wait();
    idle_inputs();
    redirect_en = 1'b1; redirect_pc = 64'h20;
    cyc();
    idle_inputs();
    flush = 1'b1;
    cyc();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL flush_instr got %h exp %h", if_id_instr, NOP_INSTR); end
    checks++; if (pc !== 64'h24) begin errors++; $display("FAIL flush_pc got %h exp 24", pc); end
    idle_inputs();
    imem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (pc !== 64'h24) begin errors++; $display("FAIL wait_pc[%0d] got %h exp 24", i, pc); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got %b exp 0", i, if_id_valid); end
      checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL wait_instr[%0d] got %h exp %h", i, if_id_instr, NOP_INSTR); end
      checks++; if (if_id_pc !== 64'h24) begin errors++; $display("FAIL wait_ifid_pc[%0d] got %h exp 24", i, if_id_pc); end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] w;
    idle_inputs();
    redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_redir_pc got %h exp fffffffffffffffc", pc); end
    idle_inputs();
    w = imem_rdata;
    cyc();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
    checks++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_ifid_pc got %h exp fffffffffffffffc", if_id_pc); end
    checks++; if (if_id_instr !== w) begin errors++; $display("FAIL wrap_instr got %h exp %h", if_id_instr, w); end
    idle_inputs();
    cyc();
    reset = 1'b0; stall = 1'b1;
    cyc();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL midrst_pc got %h exp %h", pc, RESET_PC); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL midrst_instr got %h exp %h", if_id_instr, NOP_INSTR); end
    checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL midrst_ifid_pc got %h exp 0", if_id_pc); end
    idle_inputs();
    w = imem_rdata;
    cyc();
    checks++; if (if_id_pc !== RESET_PC) begin errors++; $display("FAIL postrst_ifid_pc got %h exp %h", if_id_pc, RESET_PC); end
    checks++; if (if_id_instr !== w) begin errors++; $display("FAIL postrst_instr got %h exp %h", if_id_instr, w); end
    checks++; if (pc !== RESET_PC + 64'd4) begin errors++; $display("FAIL postrst_pc got %h exp %h", pc, RESET_PC + 64'd4); end
  endtask

`ifdef IF_ID_PERF_COUNTERS_EN
  task automatic test_perf();
    idle_inputs();
    reset = 1'b0;
    cyc();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom();
      cyc();
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    idle_inputs();
    imem_valid = 1'b0;
    cyc();
    checks++; if (perf_fetched !== 64'd5) begin errors++; $display("FAIL perf_fetched got %0d exp 5", perf_fetched); end
    checks++; if (perf_stall_cycles !== 64'd3) begin errors++; $display("FAIL perf_stalls got %0d exp 3", perf_stall_cycles); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 5) == 0);
      redirect_en = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      imem_valid  = ($urandom_range(0, 3) != 0);
      imem_rdata  = $urandom();
      cyc();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] got %h exp %h", i, pc, m_pc); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr[%0d] got %h exp %h", i, imem_addr, m_pc); end
      checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b exp %b", i, if_id_valid, m_valid); end
      checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rand_instr[%0d] got %h exp %h", i, if_id_instr, m_instr); end
      checks++; if (if_id_pc !== m_ipc) begin errors++; $display("FAIL rand_ifid_pc[%0d] got %h exp %h", i, if_id_pc, m_ipc); end
`ifdef IF_ID_PERF_COUNTERS_EN
      checks++; if (perf_fetched !== m_fetched) begin errors++; $display("FAIL rand_perf_fetched[%0d] got %0d exp %0d", i, perf_fetched, m_fetched); end
      checks++; if (perf_stall_cycles !== m_stalls) begin errors++; $display("FAIL rand_perf_stalls[%0d] got %0d exp %0d", i, perf_stall_cycles, m_stalls); end
`endif
    end
  endtask

  initial begin
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 64'h0; m_valid = 1'b0;
    m_fetched = 64'h0; m_stalls = 64'h0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_flush_wait();
    test_wrap_reset();
`ifdef IF_ID_PERF_COUNTERS_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 64-bit pipelined LEGv8 core.
- Holds the PC and drives the instruction-memory address.
- Captures the returned 32-bit word into the IF/ID register. Its `if_id_instr` output feeds the decode-stage sign extender and the register-file read ports.
- Handles hazard-unit stalls, taken-branch redirects, IF/ID flushes and instruction-memory wait cycles.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, encoding placed in `if_id_instr` for bubbles.

Ports:
- clk  input  1  single core clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- imem_addr  output  64  fetch address; always equals `pc`.
- imem_rdata  input  32  instruction word for `imem_addr`.
- imem_valid  input  1  `imem_rdata` is valid this cycle.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  squash the IF/ID contents (insert bubble).
- redirect_en  input  1  taken branch: load `redirect_pc`.
- redirect_pc  input  64  branch/jump target from the later stage.
- pc  output  64  current fetch PC.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc  output  64  PC of `if_id_instr`.
- if_id_valid  output  1  `if_id_instr` is a real instruction.

Behaviour:
- All state updates on the rising edge of `clk`. `imem_addr` = `pc`, combinational.
- Reset (`reset`=0 at an edge), overriding everything:
  - `pc`=RESET_PC
  - `if_id_instr`=NOP_INSTR
  - `if_id_pc`=0
  - `if_id_valid`=0
  - Reset mid-operation discards any in-flight fetch; the first fetch is at RESET_PC in the cycle after `reset` returns to 1.
- Per-cycle priority: reset > redirect_en > stall > flush > imem wait > normal.
- Normal (`imem_valid`=1, no control inputs):
  - `if_id_instr`<=`imem_rdata`, `if_id_pc`<=`pc`, `if_id_valid`<=1, `pc`<=`pc`+4.
  - Latency: word fetched in cycle N is on `if_id_instr` in cycle N+1.
- Imem wait (`imem_valid`=0, no control inputs): `pc` held; IF/ID loads a bubble (NOP_INSTR, `if_id_valid`=0, `if_id_pc`<=`pc`).
- redirect_en=1:
  - `pc`<={`redirect_pc`[63:2],2'b00}; IF/ID loads a bubble.
  - Applies even when `stall` or `flush` is also 1; the word on `imem_rdata` is dropped.
- stall=1 (no redirect): `pc` and all IF/ID outputs hold their values; `imem_valid` is ignored.
  - stall+flush together: stall wins, IF/ID holds. Flush must be re-asserted once the stall drops.
- flush=1 (no redirect, no stall): IF/ID loads a bubble; `pc`<=`pc`+4 if `imem_valid`=1, else `pc` held.
- PC arithmetic: 64-bit unsigned and wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 = 0). `pc`[1:0] is always 0.
- Fetch carries no knowledge of the instruction's content; decode does the sign extension.

Optional Feature:
- Macro: IF_ID_PERF_COUNTERS_EN.
- With the macro defined, add outputs:
  - `perf_fetched` (64): increments on each edge where IF/ID loads with `if_id_valid`<=1.
  - `perf_stall_cycles` (64): increments on each edge with `stall`=1 and `reset`=1.
  - Both reset to 0 and wrap silently.
- Without the macro, these ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then stream: `reset`=0 for 2 cycles, then 1, `imem_valid`=1, `imem_rdata`=32'h8B020020 then 32'h91000421.
  - Expect `pc` 0→4→8.
  - Expect `if_id_instr`=32'h8B020020 with `if_id_pc`=0, then 32'h91000421 with `if_id_pc`=4, `if_id_valid`=1.
- Stall: at `pc`=8, `stall`=1 for 3 cycles.
  - Expect `pc` stays 8 and `if_id_instr`/`if_id_pc`=4 hold.
  - After release, the next edge loads the word at 8 and `pc`=12.
- Redirect with stall: `redirect_en`=1, `redirect_pc`=64'h0000_0000_0000_0103, `stall`=1.
  - Expect `pc`=64'h100 next cycle, `if_id_valid`=0, `if_id_instr`=32'hD503201F.
- Flush and imem wait:
  - `flush`=1 with `imem_valid`=1 at `pc`=0x20: `if_id_valid`=0, `pc`=0x24.
  - Then `imem_valid`=0 for 2 cycles: `pc` holds 0x24, bubbles both cycles.
- Wrap and mid-run reset:
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC then one normal fetch: `pc`=0, `if_id_pc`=64'hFFFF_FFFF_FFFF_FFFC.
  - Assert `reset`=0 mid-stream: outputs return to reset values on the next edge.
- With IF_ID_PERF_COUNTERS_EN: 5 valid fetches + 3 stall cycles → `perf_fetched`=5, `perf_stall_cycles`=3.
